// File: rtl/calc_pkg.sv
// Shared types for the calculator front end: opcode and sequencer state encodings.
package calc_pkg;

   localparam int CALC_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_NONE   = 3'd0,
      OP_EQUALS = 3'd1,
      OP_ADD    = 3'd2,
      OP_SUB    = 3'd3,
      OP_MUL    = 3'd4,
      OP_DIV    = 3'd5,
      OP_CLEAR  = 3'd6
   } opcode_e;

   typedef enum logic [2:0] {
      ENTER_A,
      ENTER_B,
      EXEC,
      RESULT,
      ERROR
   } state_e;

   function automatic logic is_arith(input logic [2:0] code);
      return (code >= OP_ADD) && (code <= OP_DIV);
   endfunction

endpackage

// File: rtl/calc_key_edge.sv
// Keypad front end: one-shot digit and operator events from level-held inputs.
module calc_key_edge
   import calc_pkg::*;
(
   input  logic       clk,
   input  logic       pwr,
   input  logic [9:0] btn,
   input  logic [2:0] opcode,
   output logic       digit_valid,
   output logic [3:0] digit,
   output logic       op_valid,
   output logic [2:0] op_code
);

   logic [9:0] btn_q;
   logic [2:0] opcode_q;
   logic       btn_onehot;
   logic       digit_edge;
   logic       op_edge;
   logic [3:0] btn_index;

   // A press only arms from an all-released keypad, so multi-hot chords never fire.
   assign btn_onehot = (btn != '0) && ((btn & (btn - 10'd1)) == '0);
   assign digit_edge = (btn_q == '0) && btn_onehot;
   assign op_edge    = (opcode_q == OP_NONE) && (opcode != OP_NONE);

   always_comb begin
      btn_index = '0;
      for (int i = 0; i < 10; i++) begin
         if (btn[i]) btn_index = 4'(i);
      end
   end

   // History always tracks the inputs, so reset leaves held keys counted as seen.
   always_ff @(posedge clk) begin
      btn_q    <= btn;
      opcode_q <= opcode;
      if (pwr) begin
         digit_valid <= 1'b0;
         digit       <= '0;
         op_valid    <= 1'b0;
         op_code     <= OP_NONE;
      end else begin
         digit_valid <= digit_edge;
         digit       <= btn_index;
         op_valid    <= op_edge && !digit_edge;
         op_code     <= opcode;
      end
   end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: operand entry, operator latching and ALU start/done sequencing.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int WIDTH       = CALC_WIDTH,
   parameter int MAX_DIGITS  = 9,
   parameter int ALU_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             pwr,
   input  logic [9:0]       btn,
   input  logic [2:0]       opcode,
   output logic             alu_start,
   output logic [2:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic             alu_done,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_err,
   output logic             num,
   output logic             op,
   output logic [WIDTH-1:0] val1,
   output logic [WIDTH-1:0] val2,
   output logic [WIDTH-1:0] displayedNum,
   output logic             err,
   output state_e           dbg_state
);

   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam int TW = $clog2(ALU_TIMEOUT);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
   localparam logic [TW-1:0] TO_LAST = TW'(ALU_TIMEOUT - 1);

   logic             digit_valid, op_valid, arith, equals, clear;
   logic [3:0]       digit;
   logic [2:0]       op_code;
   state_e           state, state_n;
   logic [WIDTH-1:0] val1_n, val2_n, disp_n, alu_a_n, alu_b_n, acc_src, acc;
   logic [2:0]       alu_op_n, pend_op, pend_n, chain_op, chain_op_n;
   logic             alu_start_n, num_n, op_n, err_n, chain, chain_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [TW-1:0]    timer, timer_n;

   calc_key_edge u_key_edge (
      .clk        (clk),
      .pwr        (pwr),
      .btn        (btn),
      .opcode     (opcode),
      .digit_valid(digit_valid),
      .digit      (digit),
      .op_valid   (op_valid),
      .op_code    (op_code)
   );

   assign arith     = op_valid && is_arith(op_code);
   assign equals    = op_valid && (op_code == OP_EQUALS);
   assign clear     = op_valid && (op_code == OP_CLEAR);
   assign acc_src   = (state == ENTER_B) ? val2 : val1;
   assign acc       = acc_src * WIDTH'(10) + WIDTH'(digit);
   assign dbg_state = state;

   // ALU handshake: alu_start pulses for one cycle while alu_op/alu_a/alu_b are
   // loaded; those hold until alu_done, a one-cycle pulse qualifying alu_result/alu_err.
   always_comb begin
      state_n     = state;
      val1_n      = val1;
      val2_n      = val2;
      disp_n      = displayedNum;
      alu_a_n     = alu_a;
      alu_b_n     = alu_b;
      alu_op_n    = alu_op;
      alu_start_n = 1'b0;
      num_n       = num;
      op_n        = op;
      err_n       = err;
      pend_n      = pend_op;
      cnt_n       = cnt;
      chain_n     = chain;
      chain_op_n  = chain_op;
      timer_n     = '0;
      if (clear) begin
         state_n  = ENTER_A;
         val1_n   = '0;
         val2_n   = '0;
         disp_n   = '0;
         alu_a_n  = '0;
         alu_b_n  = '0;
         alu_op_n = OP_NONE;
         num_n    = 1'b0;
         op_n     = 1'b0;
         err_n    = 1'b0;
         pend_n   = OP_NONE;
         cnt_n    = '0;
         chain_n  = 1'b0;
      end else begin
         case (state)
            ENTER_A, ENTER_B: begin
               if (digit_valid) begin
                  if (cnt < MAX_CNT) begin
                     if (state == ENTER_A) val1_n = acc;
                     else                  val2_n = acc;
                     disp_n = acc;
                     cnt_n  = cnt + CW'(1);
                     num_n  = 1'b1;
                  end
               end else if (state == ENTER_A) begin
                  if (arith) begin
                     pend_n  = op_code;
                     op_n    = 1'b1;
                     num_n   = 1'b0;
                     val2_n  = '0;
                     cnt_n   = '0;
                     state_n = ENTER_B;
                  end
               end else if (equals || (arith && cnt != '0)) begin
                  state_n     = EXEC;
                  alu_start_n = 1'b1;
                  alu_a_n     = val1;
                  alu_b_n     = val2;
                  alu_op_n    = pend_op;
                  num_n       = 1'b0;
                  chain_n     = arith;
                  chain_op_n  = op_code;
               end else if (arith) begin
                  pend_n = op_code;
               end
            end
            EXEC: begin
               if ((alu_done && alu_err) || (!alu_done && timer == TO_LAST)) begin
                  state_n = ERROR;
                  err_n   = 1'b1;
                  disp_n  = '0;
                  op_n    = 1'b0;
                  chain_n = 1'b0;
               end else if (alu_done) begin
                  val1_n  = alu_result;
                  disp_n  = alu_result;
                  val2_n  = '0;
                  chain_n = 1'b0;
                  if (chain) begin
                     pend_n  = chain_op;
                     op_n    = 1'b1;
                     cnt_n   = '0;
                     state_n = ENTER_B;
                  end else begin
                     op_n    = 1'b0;
                     state_n = RESULT;
                  end
               end else begin
                  timer_n = timer + TW'(1);
               end
            end
            RESULT, ERROR: begin
               if (digit_valid) begin
                  val1_n  = WIDTH'(digit);
                  disp_n  = WIDTH'(digit);
                  val2_n  = '0;
                  cnt_n   = CW'(1);
                  num_n   = 1'b1;
                  op_n    = 1'b0;
                  err_n   = 1'b0;
                  state_n = ENTER_A;
               end else if (arith && state == RESULT) begin
                  pend_n  = op_code;
                  op_n    = 1'b1;
                  num_n   = 1'b0;
                  val2_n  = '0;
                  cnt_n   = '0;
                  state_n = ENTER_B;
               end
            end
            default: state_n = ENTER_A;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (pwr) begin
         state        <= ENTER_A;
         val1         <= '0;
         val2         <= '0;
         displayedNum <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= OP_NONE;
         alu_start    <= 1'b0;
         num          <= 1'b0;
         op           <= 1'b0;
         err          <= 1'b0;
         pend_op      <= OP_NONE;
         cnt          <= '0;
         chain        <= 1'b0;
         chain_op     <= OP_NONE;
         timer        <= '0;
      end else begin
         state        <= state_n;
         val1         <= val1_n;
         val2         <= val2_n;
         displayedNum <= disp_n;
         alu_a        <= alu_a_n;
         alu_b        <= alu_b_n;
         alu_op       <= alu_op_n;
         alu_start    <= alu_start_n;
         num          <= num_n;
         op           <= op_n;
         err          <= err_n;
         pend_op      <= pend_n;
         cnt          <= cnt_n;
         chain        <= chain_n;
         chain_op     <= chain_op_n;
         timer        <= timer_n;
      end
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: keypad driver, reactive ALU model, reference calculator and request scoreboard.
module tb_calc_sequencer;
   import calc_pkg::*;

   localparam int W    = 32;
   localparam int MAXD = 9;

   logic         clk = 1'b0;
   logic         pwr;
   logic [9:0]   btn;
   logic [2:0]   opcode;
   logic         alu_start, alu_done, alu_err, num, op, err;
   logic [2:0]   alu_op;
   logic [W-1:0] alu_a, alu_b, alu_result, val1, val2, displayedNum;
   state_e       dbg_state;

   always #5 clk = ~clk;

   calc_sequencer #(.WIDTH(W), .MAX_DIGITS(MAXD), .ALU_TIMEOUT(64)) dut (
      .clk(clk), .pwr(pwr), .btn(btn), .opcode(opcode),
      .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
      .num(num), .op(op), .val1(val1), .val2(val2),
      .displayedNum(displayedNum), .err(err), .dbg_state(dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_starts = 0;
   int n_reqs   = 0;
   int alu_mode = 0;  // 0: answers after alu_lat cycles, 1: answers far too late
   int alu_lat  = 4;
   logic [3+2*W-1:0] exp_q[$];

   // reference calculator
   logic [W-1:0] m_val1, m_val2, m_disp, m_alu_a, m_alu_b;
   logic [2:0]   m_pend, m_alu_op;
   logic         m_num, m_op, m_err;
   int           m_cnt;
   state_e       m_state;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void alu_ref(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic e);
      e = 1'b0;
      r = '0;
      case (o)
         3'd2: r = a + b;
         3'd3: r = a - b;
         3'd4: r = a * b;
         3'd5: if (b == '0) e = 1'b1; else r = a / b;
         default: e = 1'b1;
      endcase
   endfunction

   task automatic model_reset();
      m_val1 = '0; m_val2 = '0; m_disp = '0;
      m_alu_a = '0; m_alu_b = '0; m_alu_op = 3'd0;
      m_pend = 3'd0; m_num = 1'b0; m_op = 1'b0; m_err = 1'b0;
      m_cnt = 0; m_state = ENTER_A;
   endtask

   task automatic push_req();
      exp_q.push_back({m_pend, m_val1, m_val2});
      n_reqs++;
      m_alu_op = m_pend; m_alu_a = m_val1; m_alu_b = m_val2;
   endtask

   task automatic model_exec(input bit chain, input logic [2:0] nc);
      logic [W-1:0] r;
      logic e;
      push_req();
      m_num = 1'b0;
      if (alu_mode != 0) begin
         e = 1'b1; r = '0;
      end else begin
         alu_ref(m_pend, m_val1, m_val2, r, e);
      end
      if (e) begin
         m_err = 1'b1; m_disp = '0; m_op = 1'b0; m_state = ERROR;
      end else begin
         m_val1 = r; m_disp = r; m_val2 = '0;
         if (chain) begin
            m_pend = nc; m_op = 1'b1; m_cnt = 0; m_state = ENTER_B;
         end else begin
            m_op = 1'b0; m_state = RESULT;
         end
      end
   endtask

   task automatic model_digit(input int d);
      logic [W-1:0] dv;
      dv = W'(d);
      case (m_state)
         ENTER_A: if (m_cnt < MAXD) begin
            m_val1 = m_val1 * 10 + dv; m_disp = m_val1; m_cnt++; m_num = 1'b1;
         end
         ENTER_B: if (m_cnt < MAXD) begin
            m_val2 = m_val2 * 10 + dv; m_disp = m_val2; m_cnt++; m_num = 1'b1;
         end
         RESULT, ERROR: begin
            m_val1 = dv; m_disp = dv; m_val2 = '0; m_cnt = 1;
            m_num = 1'b1; m_op = 1'b0; m_err = 1'b0; m_state = ENTER_A;
         end
         default: ;
      endcase
   endtask

   task automatic model_op(input logic [2:0] c);
      if (c == 3'd6) begin
         model_reset();
      end else if (c == 3'd1) begin
         if (m_state == ENTER_B) model_exec(1'b0, 3'd0);
      end else if (c >= 3'd2 && c <= 3'd5) begin
         case (m_state)
            ENTER_A, RESULT: begin
               m_pend = c; m_op = 1'b1; m_num = 1'b0; m_val2 = '0; m_cnt = 0; m_state = ENTER_B;
            end
            ENTER_B: if (m_cnt == 0) m_pend = c; else model_exec(1'b1, c);
            default: ;
         endcase
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".val1"}, val1, m_val1);
      chk({tag, ".val2"}, val2, m_val2);
      chk({tag, ".disp"}, displayedNum, m_disp);
      chk({tag, ".num"}, W'(num), W'(m_num));
      chk({tag, ".op"}, W'(op), W'(m_op));
      chk({tag, ".err"}, W'(err), W'(m_err));
      chk({tag, ".state"}, W'(dbg_state), W'(m_state));
      chk({tag, ".alu_a"}, alu_a, m_alu_a);
      chk({tag, ".alu_b"}, alu_b, m_alu_b);
      chk({tag, ".alu_op"}, W'(alu_op), W'(m_alu_op));
   endtask

   // driver tasks: inputs change on the falling edge
   task automatic key_digit(input int d, input int hold);
      @(negedge clk);
      btn = '0;
      btn[d] = 1'b1;
      repeat (hold) @(negedge clk);
      btn = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic key_op(input logic [2:0] c, input int hold);
      @(negedge clk);
      opcode = c;
      repeat (hold) @(negedge clk);
      opcode = 3'd0;
      repeat (2) @(negedge clk);
   endtask

   task automatic settle();
      int guard;
      guard = 0;
      repeat (3) @(negedge clk);
      while (dbg_state == EXEC && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL exec_wait: still in EXEC after %0d cycles, required exit", guard);
      end
      @(negedge clk);
   endtask

   task automatic do_digit(input int d, input int hold);
      model_digit(d);
      key_digit(d, hold);
      settle();
      check_all($sformatf("digit%0d", d));
   endtask

   task automatic do_op(input logic [2:0] c, input int hold);
      model_op(c);
      key_op(c, hold);
      settle();
      check_all($sformatf("op%0d", c));
   endtask

   // reactive ALU
   initial begin : alu_model
      logic [W-1:0] a, b, r;
      logic [2:0]   o;
      logic         e;
      alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
      forever begin
         @(negedge clk);
         if (alu_start === 1'b1) begin
            a = alu_a; b = alu_b; o = alu_op;
            if (alu_mode == 0) repeat (alu_lat - 1) @(negedge clk);
            else repeat (100) @(negedge clk);
            alu_ref(o, a, b, r, e);
            alu_done = 1'b1; alu_result = r; alu_err = e;
            @(negedge clk);
            alu_done = 1'b0; alu_err = 1'b0;
         end
      end
   end

   // scoreboard monitor for ALU requests
   initial begin : req_monitor
      logic [3+2*W-1:0] req;
      forever begin
         @(negedge clk);
         if (alu_start === 1'b1) begin
            n_starts++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL alu_req: got start op=%0d a=%0d b=%0d, expected no request", alu_op, alu_a, alu_b);
            end else begin
               req = exp_q.pop_front();
               chk("alu_req.op", W'(alu_op), W'(req[3+2*W-1:2*W]));
               chk("alu_req.a", alu_a, req[2*W-1:W]);
               chk("alu_req.b", alu_b, req[W-1:0]);
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int s0, hold, r;
      pwr = 1'b1; btn = '0; opcode = 3'd0;
      repeat (3) @(negedge clk);
      pwr = 1'b0;
      @(negedge clk);
      model_reset();
      check_all("reset");

      // 5 ADD 3 EQUALS
      s0 = n_starts;
      alu_lat = 4;
      do_digit(5, 10);
      do_op(OP_ADD, 3);
      do_digit(3, 2);
      do_op(OP_EQUALS, 2);
      chk("one_start", W'(n_starts - s0), W'(1));

      // entry, held key, digit limit
      do_op(OP_CLEAR, 2);
      do_digit(1, 2); do_digit(2, 2); do_digit(3, 2);
      do_digit(7, 50);
      do_op(OP_CLEAR, 2);
      for (int i = 1; i <= 10; i++) do_digit(i % 10, 1);

      // chained operation
      do_op(OP_CLEAR, 2);
      do_digit(9, 2); do_op(OP_SUB, 2); do_digit(4, 2);
      do_op(OP_ADD, 2); do_digit(2, 2); do_op(OP_EQUALS, 2);

      // divide by zero, then recovery by a digit
      do_op(OP_CLEAR, 2);
      do_digit(6, 2); do_op(OP_DIV, 2); do_digit(0, 2); do_op(OP_EQUALS, 2);
      do_digit(4, 2);

      // ALU timeout and a late done
      do_op(OP_CLEAR, 2);
      alu_mode = 1;
      do_digit(8, 2); do_op(OP_MUL, 2); do_digit(2, 2); do_op(OP_EQUALS, 2);
      repeat (60) @(negedge clk);
      check_all("late_done");
      alu_mode = 0;

      // pwr during EXEC with a digit held through reset
      alu_lat = 30;
      do_op(OP_CLEAR, 2);
      do_digit(5, 2); do_op(OP_ADD, 2); do_digit(3, 2);
      push_req();
      key_op(OP_EQUALS, 1);
      chk("pwr.in_exec", W'(dbg_state), W'(EXEC));
      @(negedge clk);
      btn = 10'b00_0000_0100;
      pwr = 1'b1;
      @(negedge clk);
      pwr = 1'b0;
      model_reset();
      repeat (5) @(negedge clk);
      check_all("pwr_abort");
      repeat (40) @(negedge clk);
      check_all("pwr_late_done");
      btn = '0;
      repeat (3) @(negedge clk);
      check_all("pwr_release");

      // CLEAR during ENTER_B
      alu_lat = 4;
      do_digit(4, 2); do_op(OP_ADD, 2); do_digit(7, 2);
      do_op(OP_CLEAR, 2);

      // randomized key sequences
      for (int i = 0; i < 40; i++) begin
         r       = $urandom_range(0, 99);
         hold    = $urandom_range(1, 4);
         alu_lat = $urandom_range(2, 8);
         if (r < 60)      do_digit($urandom_range(0, 9), hold);
         else if (r < 85) do_op(3'($urandom_range(2, 5)), hold);
         else if (r < 95) do_op(OP_EQUALS, hold);
         else             do_op(OP_CLEAR, hold);
      end

      repeat (5) @(negedge clk);
      chk("start_count", W'(n_starts), W'(n_reqs));
      chk("exp_q_empty", W'(exp_q.size()), W'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Front-end controller for the calculator. Turns raw one-hot digit buttons and the 3-bit opcode bus into operand entry, operator latching and execution.
- Sequences a shared multi-cycle ALU through a start/done handshake and owns the displayed value.
- Sits between the keypad/opcode inputs and the arithmetic datapath. It replaces ad-hoc combinational accumulation of val1/val2.

Parameters:
- WIDTH, 32, operand/result width (unsigned).
- MAX_DIGITS, 9, maximum decimal digits accepted per operand; further digits are ignored.
- ALU_TIMEOUT, 64, cycles to wait for alu_done before declaring an error.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- pwr  in  1  synchronous active-high reset (power/clear).
- btn  in  10  one-hot digit buttons, btn[d] = digit d; level, held for many cycles.
- opcode  in  3  operator bus, level; 3'b000 = no key.
- alu_start  out  1  one-cycle request pulse to ALU.
- alu_op  out  3  operation code to ALU, stable from start to done.
- alu_a  out  WIDTH  operand A to ALU, stable from start to done.
- alu_b  out  WIDTH  operand B to ALU, stable from start to done.
- alu_done  in  1  one-cycle completion pulse from ALU.
- alu_result  in  WIDTH  valid when alu_done=1.
- alu_err  in  1  valid when alu_done=1 (divide-by-zero/overflow).
- num  out  1  1 while an operand is being entered.
- op  out  1  1 while an operator is latched and pending.
- val1  out  WIDTH  first operand register.
- val2  out  WIDTH  second operand register.
- displayedNum  out  WIDTH  value shown to the user.
- err  out  1  sticky error indicator, cleared by CLEAR, pwr or a new digit.

Behaviour:
- Opcodes: 000 NONE, 001 EQUALS, 010 ADD, 011 SUB, 100 MUL, 101 DIV, 110 CLEAR, 111 reserved (ignored).
- Reset (pwr=1 at clk edge):
  - State goes to ENTER_A.
  - val1, val2, displayedNum, alu_a, alu_b all 0.
  - alu_op=000; alu_start, num, op, err all 0.
  - Edge detectors are cleared and treat current inputs as "already seen".
  - pwr asserted mid-EXEC aborts the operation; a later alu_done is ignored.
- Key events:
  - A digit event is the cycle after btn goes from 0 to exactly one bit set. Holding fires once.
  - Multi-hot btn is ignored and does not arm a new event until btn returns to 0.
  - An op event is opcode going from 000 to non-zero. Holding fires once; change between two non-zero codes without passing through 000 is ignored.
  - Digit and op events in the same cycle: the digit is processed, the op is dropped.
- Digit accumulation: reg <= reg*10 + d (WIDTH-bit unsigned). After MAX_DIGITS digits for the current operand, further digits are ignored.
- States and transitions:
  - ENTER_A:
    - digit -> val1 updated, num=1, displayedNum=val1.
    - ADD..DIV -> latch pending op, op=1, go to ENTER_B with val2=0 and digit count 0.
    - EQUALS -> no action.
  - ENTER_B:
    - digit -> val2 updated, num=1, displayedNum=val2.
    - EQUALS -> go to EXEC.
    - ADD..DIV before any val2 digit -> replace the pending op.
    - ADD..DIV after a val2 digit -> EXEC, then chain: the result becomes val1, the new op is latched and the state returns to ENTER_B.
  - EXEC:
    - Cycle 1: alu_start=1, alu_a=val1, alu_b=val2, alu_op=pending. num=0.
    - Waits for alu_done. All key events are ignored.
    - On done with no alu_err: val1=displayedNum=alu_result, val2=0, op=0 (unless chaining), go to RESULT.
    - On done with alu_err, or ALU_TIMEOUT cycles without done: go to ERROR with err=1, displayedNum=0.
  - RESULT:
    - digit -> val1=d, new entry in ENTER_A.
    - ADD..DIV -> use result as val1 and go to ENTER_B.
    - EQUALS -> no action.
  - ERROR:
    - Only a digit (starts a new val1, err=0) or CLEAR is accepted.
- CLEAR in any state: same effect as reset but with no edge-detector re-seed. Takes effect next cycle. In EXEC it aborts the operation.
- Latency:
  - Key press to register/display update: 1 cycle after the detected edge (2 clk after the input change).
  - EQUALS to alu_start: 1 cycle.
  - alu_done to displayedNum: 1 cycle.
- Overflow of the accumulation multiply wraps modulo 2^WIDTH. MAX_DIGITS=9 prevents this for WIDTH=32.

Decomposition:
- Shared package calc_pkg holds:
  - the opcode_e enum (NONE, EQUALS, ADD, SUB, MUL, DIV, CLEAR);
  - the state_e enum (ENTER_A, ENTER_B, EXEC, RESULT, ERROR);
  - the WIDTH default.
- The ALU uses the same opcode_e.
- One sub-module: calc_key_edge. It does btn/opcode edge detection, the one-hot check, and produces digit_valid, digit[3:0], op_valid and op_code.

Test Plan:
- Reset, press btn[5] for 10 cycles, release, opcode 010 then 000, btn[3], opcode 001 with the ALU model returning a+b after 4 cycles -> val1=5, val2=3, exactly one alu_start with alu_a=5, alu_b=3, alu_op=010; displayedNum=8, op=0.
- Enter 1,2,3 -> displayedNum=123. Hold btn[7] for 50 cycles -> only one digit added (1237). Press 10 digits -> value stops at 9 digits.
- 9 SUB 4 ADD 2 EQUALS -> first alu_start computes 9-4=5 and displays 5 with op=1 pending ADD; second alu_start has a=5, b=2; final display 7.
- 6 DIV 0 EQUALS with ALU returning alu_err -> err=1, displayedNum=0. Then digit 4 -> err=0, val1=4.
- ALU model never asserts done -> after ALU_TIMEOUT=64 cycles the block enters ERROR, err=1. A late alu_done is ignored.
- pwr pulsed during EXEC, and separately CLEAR opcode during ENTER_B -> all outputs return to 0, state ENTER_A. A still-held btn produces no digit event.
